// File: rtl/genadc_pkg.sv
// Shared types and constant helpers for the ADC-to-BCD display generator.
package genadc_pkg;

  typedef enum logic [1:0] {
    REQ     = 2'd0,
    WAITLOW = 2'd1,
    CONV    = 2'd2,
    COMMIT  = 2'd3
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/genadcbcd_bindbl.sv
// Sequential double-dabble shifter: binary value and BCD digits share one
// shift register so the bit leaving the top of the BCD field simply drops out.
module bindbl #(
  parameter int DW = 12,
  parameter int ND = 4
) (
  input  logic              genclk,
  input  logic              reset,
  input  logic              load,
  input  logic [DW-1:0]     bin,
  input  logic              step,
  output logic [4*ND-1:0]   bcd
);

  logic [4*ND+DW-1:0] sh;
  logic [4*ND+DW-1:0] adj;

  assign bcd = sh[4*ND+DW-1 -: 4*ND];

  // add 3 to every BCD nibble that is 5 or more before the next shift
  always_comb begin
    adj = sh;
    for (int k = 0; k < ND; k++) begin
      if (sh[DW + 4*k +: 4] >= 4'd5)
        adj[DW + 4*k +: 4] = sh[DW + 4*k +: 4] + 4'd3;
    end
  end

  // load clears the digits and parks the binary value below them
  always_ff @(posedge genclk) begin
    if (reset)
      sh <= '0;
    else if (load)
      sh <= {{(4*ND){1'b0}}, bin};
    else if (step)
      sh <= adj << 1;
  end

endmodule

// File: rtl/genadcbcd.sv
// ADC sample to BCD display generator: 4-phase handshake to the ADC driver,
// optional averaging, saturating BCD conversion and a digit mux for the LCD.
//
//   state   | meaning
//   REQ     | raise adcdav when idle, capture sample on davadc
//   WAITLOW | wait for davadc to drop before a new request
//   CONV    | one double-dabble step per cycle, DW cycles
//   COMMIT  | copy digits and overflow flag, pulse bcdvalid
module genadcbcd import genadc_pkg::*; #(
  parameter int DW       = 12,
  parameter int NCH      = 2,
  parameter int ND       = 4,
  parameter int AVG_LOG2 = 0
) (
  input  logic                                      genclk,
  input  logic                                      reset,
  input  logic [((NCH > 1) ? clog2(NCH) : 1)-1:0]   chsel,
  input  logic                                      hold,
  output logic                                      adcdav,
  input  logic                                      davadc,
  input  logic [NCH*DW-1:0]                         adcdata,
  input  logic [((ND > 1) ? clog2(ND) : 1)-1:0]     digitmux,
  output logic [3:0]                                data,
  output logic                                      bcdvalid,
  output logic                                      ovf
);

  localparam int CW   = (NCH > 1) ? clog2(NCH) : 1;
  localparam int AW   = DW + AVG_LOG2;
  localparam int KW   = AVG_LOG2 + 1;
  localparam int NS   = 1 << AVG_LOG2;
  localparam int SW   = clog2(DW + 1);
  localparam int MAXV = pow10(ND) - 1;

  state_t          state, nstate;
  logic [CW-1:0]   chl;
  logic [AW-1:0]   acc, sum;
  logic [KW-1:0]   cnt;
  logic [SW-1:0]   stepcnt;
  logic [DW-1:0]   sample, val, ldval;
  logic            last, over, ovf_n;
  logic            req_go, cap, step, commit;
  logic [4*ND-1:0] bcd, digits;

  // select the latched channel and form the batch result
  always_comb begin
    sample = '0;
    for (int k = 0; k < NCH; k++) begin
      if (int'(chl) == k) sample = adcdata[k*DW +: DW];
    end
    sum   = acc + AW'(sample);
    last  = (cnt == KW'(NS - 1));
    val   = DW'(sum >> AVG_LOG2);
    over  = (32'(val) > 32'(MAXV));
    ldval = over ? DW'(MAXV) : val;
  end

  // state register
  always_ff @(posedge genclk) begin
    if (reset) state <= REQ;
    else       state <= nstate;
  end

  // next state and per-cycle strobes
  always_comb begin
    nstate = state;
    req_go = 1'b0;
    cap    = 1'b0;
    step   = 1'b0;
    commit = 1'b0;
    case (state)
      REQ: begin
        if (adcdav && davadc) begin
          cap    = 1'b1;
          nstate = last ? CONV : WAITLOW;
        end else if (!adcdav && !davadc && !hold) begin
          req_go = 1'b1;
        end
      end
      WAITLOW: if (!davadc) nstate = REQ;
      CONV: begin
        step = 1'b1;
        if (stepcnt == '0) nstate = COMMIT;
      end
      COMMIT: begin
        commit = 1'b1;
        nstate = WAITLOW;
      end
      default: nstate = REQ;
    endcase
  end

  // handshake, accumulator, step timer and committed digits
  always_ff @(posedge genclk) begin
    if (reset) begin
      adcdav   <= 1'b0;
      bcdvalid <= 1'b0;
      ovf      <= 1'b0;
      ovf_n    <= 1'b0;
      chl      <= '0;
      acc      <= '0;
      cnt      <= '0;
      stepcnt  <= '0;
      digits   <= '0;
    end else begin
      bcdvalid <= commit;
      if (req_go) begin
        adcdav <= 1'b1;
        if (cnt == '0) chl <= (int'(chsel) < NCH) ? chsel : '0;
      end
      if (cap) begin
        adcdav <= 1'b0;
        if (last) begin
          acc     <= '0;
          cnt     <= '0;
          ovf_n   <= over;
          stepcnt <= SW'(DW - 1);
        end else begin
          acc <= sum;
          cnt <= cnt + 1'b1;
        end
      end
      if (step && stepcnt != '0) stepcnt <= stepcnt - 1'b1;
      if (commit) begin
        digits <= bcd;
        ovf    <= ovf_n;
      end
    end
  end

  bindbl #(.DW(DW), .ND(ND)) u_dd (
    .genclk (genclk),
    .reset  (reset),
    .load   (cap && last),
    .bin    (ldval),
    .step   (step),
    .bcd    (bcd)
  );

  // digit mux; out-of-range selects read as zero
  always_comb begin
    data = 4'd0;
    for (int k = 0; k < ND; k++) begin
      if (int'(digitmux) == k) data = digits[k*4 +: 4];
    end
  end

endmodule

// File: tb/tb_genadcbcd.sv
// Directed bench for genadcbcd: instance a (3 channels, 4 digits, no
// averaging) and instance b (1 channel, 3 digits, 4-sample averaging).
module tb_genadcbcd;

  logic        genclk = 1'b0;
  logic        reset  = 1'b1;

  logic [1:0]  chsel_a    = 2'd0;
  logic        hold_a     = 1'b0;
  logic        adcdav_a;
  logic        davadc_a   = 1'b0;
  logic [35:0] adcdata_a  = '0;
  logic [1:0]  digitmux_a = 2'd0;
  logic [3:0]  data_a;
  logic        bcdvalid_a;
  logic        ovf_a;

  logic [0:0]  chsel_b    = 1'b0;
  logic        hold_b     = 1'b0;
  logic        adcdav_b;
  logic        davadc_b   = 1'b0;
  logic [11:0] adcdata_b  = '0;
  logic [1:0]  digitmux_b = 2'd0;
  logic [3:0]  data_b;
  logic        bcdvalid_b;
  logic        ovf_b;

  int nvec = 0;
  int nbad = 0;

  always #10 genclk = ~genclk;

  genadcbcd #(.DW(12), .NCH(3), .ND(4), .AVG_LOG2(0)) dut_a (
    .genclk(genclk), .reset(reset), .chsel(chsel_a), .hold(hold_a),
    .adcdav(adcdav_a), .davadc(davadc_a), .adcdata(adcdata_a),
    .digitmux(digitmux_a), .data(data_a), .bcdvalid(bcdvalid_a), .ovf(ovf_a)
  );

  genadcbcd #(.DW(12), .NCH(1), .ND(3), .AVG_LOG2(2)) dut_b (
    .genclk(genclk), .reset(reset), .chsel(chsel_b), .hold(hold_b),
    .adcdav(adcdav_b), .davadc(davadc_b), .adcdata(adcdata_b),
    .digitmux(digitmux_b), .data(data_b), .bcdvalid(bcdvalid_b), .ovf(ovf_b)
  );

  function automatic logic [35:0] pk(input logic [11:0] c0, c1, c2);
    return {c2, c1, c0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nbad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input int u, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge genclk);
      if ((u == 0) ? adcdav_a : adcdav_b) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // returns at the negedge right after the capture edge
  task automatic capture(input int u, output bit ok);
    wait_req(u, ok);
    chk("req_seen", 32'(ok), 32'd1);
    if (ok) begin
      if (u == 0) davadc_a = 1'b1; else davadc_b = 1'b1;
      @(posedge genclk);
      @(negedge genclk);
      if (u == 0) davadc_a = 1'b0; else davadc_b = 1'b0;
      chk("req_drop", 32'((u == 0) ? adcdav_a : adcdav_b), 32'd0);
    end
  endtask

  task automatic watch(input int u, input int n, output int first, output int cnt, output int reqs);
    first = -1;
    cnt   = 0;
    reqs  = 0;
    for (int i = 0; i < n; i++) begin
      if ((u == 0) ? bcdvalid_a : bcdvalid_b) begin
        cnt++;
        if (first < 0) first = i;
      end
      if ((u == 0) ? adcdav_a : adcdav_b) reqs++;
      @(negedge genclk);
    end
  endtask

  task automatic rd(input int u, output logic [15:0] d);
    d = '0;
    for (int k = 0; k < 4; k++) begin
      if (u == 0) digitmux_a = 2'(k); else digitmux_b = 2'(k);
      #1;
      d[k*4 +: 4] = (u == 0) ? data_a : data_b;
    end
  endtask

  task automatic a_conv(input string tag, input logic [15:0] ed);
    bit ok; int f, c, r; logic [15:0] d;
    capture(0, ok);
    watch(0, 20, f, c, r);
    chk({tag, "_lat"}, 32'(f), 32'd13);
    chk({tag, "_cnt"}, 32'(c), 32'd1);
    rd(0, d);
    chk({tag, "_dig"}, 32'(d), 32'(ed));
    chk({tag, "_ovf"}, 32'(ovf_a), 32'd0);
  endtask

  task automatic b_batch(input string tag, input logic [11:0] s0, s1, s2, s3,
                         input logic [15:0] ed, input logic eo);
    logic [11:0] s[4];
    bit ok; int f, c, r; logic [15:0] d;
    int early = 0;
    int hs = 0;
    s = '{s0, s1, s2, s3};
    for (int k = 0; k < 4; k++) begin
      adcdata_b = s[k];
      capture(1, ok);
      if (ok) hs++;
      watch(1, 20, f, c, r);
      if (k < 3) early += c;
    end
    chk({tag, "_early"}, 32'(early), 32'd0);
    chk({tag, "_hs"}, 32'(hs), 32'd4);
    chk({tag, "_lat"}, 32'(f), 32'd13);
    chk({tag, "_cnt"}, 32'(c), 32'd1);
    rd(1, d);
    chk({tag, "_dig"}, 32'(d), 32'(ed));
    chk({tag, "_ovf"}, 32'(ovf_b), 32'(eo));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok; int f, c, r, c2, rise; logic [15:0] d;

    adcdata_a = pk(12'd4095, 12'd7, 12'd555);
    repeat (3) @(negedge genclk);
    chk("rst_adcdav_a", 32'(adcdav_a), 32'd0);
    chk("rst_bcdvalid_a", 32'(bcdvalid_a), 32'd0);
    chk("rst_ovf_a", 32'(ovf_a), 32'd0);
    chk("rst_data_a", 32'(data_a), 32'd0);
    chk("rst_adcdav_b", 32'(adcdav_b), 32'd0);
    chk("rst_data_b", 32'(data_b), 32'd0);
    reset = 1'b0;

    b_batch("sat",   12'd1234, 12'd1234, 12'd1234, 12'd1234, 16'h0999, 1'b1);
    b_batch("small", 12'd42,   12'd42,   12'd42,   12'd42,   16'h0042, 1'b0);
    b_batch("avg",   12'd100,  12'd101,  12'd102,  12'd103,  16'h0101, 1'b0);
    b_batch("edge",  12'd999,  12'd999,  12'd999,  12'd999,  16'h0999, 1'b0);
    b_batch("over",  12'd1000, 12'd1000, 12'd1000, 12'd1000, 16'h0999, 1'b1);

    // a: request already latched channel 0 while b was being exercised
    capture(0, ok);
    chsel_a = 2'd1;
    watch(0, 20, f, c, r);
    chk("full_lat", 32'(f), 32'd13);
    chk("full_cnt", 32'(c), 32'd1);
    rd(0, d);
    chk("full_dig", 32'(d), 32'h4095);
    chk("full_ovf", 32'(ovf_a), 32'd0);

    capture(0, ok);
    chsel_a = 2'd3;
    watch(0, 20, f, c, r);
    rd(0, d);
    chk("ch1_dig", 32'(d), 32'h0007);

    adcdata_a = pk(12'd1234, 12'd7, 12'd555);
    a_conv("ch3", 16'h1234);

    chsel_a = 2'd2;
    adcdata_a = pk(12'd321, 12'd7, 12'd555);
    a_conv("midsel", 16'h0321);
    a_conv("ch2", 16'h0555);

    adcdata_a = pk(12'd321, 12'd7, 12'd888);
    wait_req(0, ok);
    chk("hs_req", 32'(ok), 32'd1);
    davadc_a = 1'b1;
    @(posedge genclk);
    @(negedge genclk);
    chk("hs_drop", 32'(adcdav_a), 32'd0);
    watch(0, 20, f, c, r);
    chk("hs_cnt", 32'(c), 32'd1);
    chk("hs_noreq", 32'(r), 32'd0);
    rd(0, d);
    chk("hs_dig", 32'(d), 32'h0888);
    davadc_a = 1'b0;
    rise = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge genclk);
      if (adcdav_a) begin
        rise = i;
        break;
      end
    end
    chk("hs_rise", 32'(rise >= 1 && rise <= 2), 32'd1);

    adcdata_a = pk(12'd321, 12'd7, 12'd2345);
    capture(0, ok);
    hold_a = 1'b1;
    watch(0, 30, f, c, r);
    chk("hold_cnt", 32'(c), 32'd1);
    chk("hold_noreq", 32'(adcdav_a), 32'd0);
    rd(0, d);
    chk("hold_dig", 32'(d), 32'h2345);
    adcdata_a = pk(12'd111, 12'd111, 12'd111);
    davadc_a = 1'b1;
    watch(0, 3, f, c, r);
    davadc_a = 1'b0;
    watch(0, 10, f, c2, r);
    chk("stray_cnt", 32'(c + c2), 32'd0);
    chk("stray_noreq", 32'(adcdav_a), 32'd0);
    rd(0, d);
    chk("stray_dig", 32'(d), 32'h2345);
    hold_a = 1'b0;

    adcdata_a = pk(12'd321, 12'd7, 12'd2222);
    capture(0, ok);
    watch(0, 5, f, c, r);
    reset = 1'b1;
    @(posedge genclk);
    @(negedge genclk);
    reset = 1'b0;
    chk("mrst_adcdav", 32'(adcdav_a), 32'd0);
    chk("mrst_ovf_b", 32'(ovf_b), 32'd0);
    rd(0, d);
    chk("mrst_dig_a", 32'(d), 32'h0000);
    rd(1, d);
    chk("mrst_dig_b", 32'(d), 32'h0000);
    watch(0, 20, f, c, r);
    chk("mrst_novalid", 32'(c), 32'd0);

    adcdata_a = pk(12'd3456, 12'd7, 12'd3456);
    a_conv("after", 16'h3456);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
